// File: rtl/bldc_commutator.sv
// bldc_commutator: six-step BLDC commutation with hall filtering, reversal dead time, hall fault latch and step counter
module bldc_commutator #(
    parameter int DUTY_CYCLE_WIDTH    = 10,
    parameter int HALL_FILTER_CYCLES  = 8,
    parameter int REVERSE_DEAD_CYCLES = 256,
    parameter int HALL_FAULT_CYCLES   = 1024
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic                        enable,
    input  logic [2:0]                  hall,
    input  logic [DUTY_CYCLE_WIDTH:0]   duty_cmd,
    input  logic                        fault_clear,
    output logic [DUTY_CYCLE_WIDTH-1:0] duty_a,
    output logic [DUTY_CYCLE_WIDTH-1:0] duty_b,
    output logic [DUTY_CYCLE_WIDTH-1:0] duty_c,
    output logic                        high_z_a,
    output logic                        high_z_b,
    output logic                        high_z_c,
    output logic                        fault,
    output logic [15:0]                 hall_count
);
    localparam int W   = DUTY_CYCLE_WIDTH;
    localparam int FCW = $clog2(HALL_FAULT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, RUN, DEAD, FLT} state_t;

    function automatic logic [2:0] fwd_next(input logic [2:0] h);
        return h == 3'd1 ? 3'd3 : h == 3'd3 ? 3'd2 : h == 3'd2 ? 3'd6 :
               h == 3'd6 ? 3'd4 : h == 3'd4 ? 3'd5 : h == 3'd5 ? 3'd1 : 3'd0;
    endfunction

    state_t           state_q, state_d;
    logic             dir_q, dir_d;
    logic [2:0]       sync1_q, sync2_q, cand_q, filt_q, filt_d;
    logic [7:0]       run_q, run_d;
    logic [15:0]      dead_q, dead_d, count_q, count_d;
    logic [FCW-1:0]   fc_q, fc_d;
    logic [W-1:0]     da_q, db_q, dc_q, da_d, db_d, dc_d, mag;
    logic [W:0]       abs_v;
    logic [2:0]       hz_q, hz_d, pos_f, neg_f, hi, lo;
    logic             fault_q, fault_d, sign, hall_bad, drive, step_fwd, step_rev;

    always_comb begin
        run_d    = sync2_q != cand_q ? 8'd1 : run_q == 8'(HALL_FILTER_CYCLES) ? run_q : run_q + 8'd1;
        filt_d   = run_d == 8'(HALL_FILTER_CYCLES) ? sync2_q : filt_q;
        // fwd_next returns 0 only for invalid codes, so a nonzero match implies both ends are valid
        step_fwd = fwd_next(filt_q) == filt_d && filt_d != 3'd0;
        step_rev = fwd_next(filt_d) == filt_q && filt_q != 3'd0;
        count_d  = count_q + (step_fwd ? 16'd1 : step_rev ? 16'hFFFF : 16'd0);
        sign     = duty_cmd[W];
        abs_v    = sign ? -duty_cmd : duty_cmd;
        mag      = abs_v[W] ? '1 : abs_v[W-1:0];
        hall_bad = filt_q == 3'd0 || filt_q == 3'd7;
    end

    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        dead_d  = dead_q;
        fc_d    = '0;
        case (state_q)
            IDLE: if (enable && mag != '0) begin
                state_d = RUN;
                dir_d   = sign;
            end
            RUN: begin
                fc_d = hall_bad ? fc_q + FCW'(1) : '0;
                if (hall_bad && fc_q == FCW'(HALL_FAULT_CYCLES - 1))
                    state_d = FLT;
                else if (!enable || mag == '0)
                    state_d = IDLE;
                else if (sign != dir_q) begin
                    state_d = DEAD;
                    dead_d  = '0;
                end
            end
            DEAD: if (!enable)
                state_d = IDLE;
            else if (dead_q == 16'(REVERSE_DEAD_CYCLES - 1)) begin
                state_d = RUN;
                dir_d   = sign;
            end else
                dead_d = dead_q + 16'd1;
            default: if (fault_clear && !enable) state_d = IDLE;
        endcase
    end

    always_comb begin
        pos_f   = filt_q == 3'd1 || filt_q == 3'd3 ? 3'b001 :
                  filt_q == 3'd2 || filt_q == 3'd6 ? 3'b010 :
                  filt_q == 3'd4 || filt_q == 3'd5 ? 3'b100 : 3'b000;
        neg_f   = filt_q == 3'd6 || filt_q == 3'd4 ? 3'b001 :
                  filt_q == 3'd1 || filt_q == 3'd5 ? 3'b010 :
                  filt_q == 3'd3 || filt_q == 3'd2 ? 3'b100 : 3'b000;
        hi      = dir_d ? neg_f : pos_f;
        lo      = dir_d ? pos_f : neg_f;
        drive   = state_d == RUN && !hall_bad;
        hz_d    = drive ? ~(hi | lo) : 3'b111;
        da_d    = drive && hi[0] ? mag : '0;
        db_d    = drive && hi[1] ? mag : '0;
        dc_d    = drive && hi[2] ? mag : '0;
        fault_d = state_d == FLT;
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= IDLE;
            dir_q   <= 1'b0;
            sync1_q <= '0;
            sync2_q <= '0;
            cand_q  <= '0;
            filt_q  <= '0;
            run_q   <= '0;
            dead_q  <= '0;
            fc_q    <= '0;
            count_q <= '0;
            hz_q    <= 3'b111;
            da_q    <= '0;
            db_q    <= '0;
            dc_q    <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            sync1_q <= hall;
            sync2_q <= sync1_q;
            cand_q  <= sync2_q;
            filt_q  <= filt_d;
            run_q   <= run_d;
            dead_q  <= dead_d;
            fc_q    <= fc_d;
            count_q <= count_d;
            hz_q    <= hz_d;
            da_q    <= da_d;
            db_q    <= db_d;
            dc_q    <= dc_d;
            fault_q <= fault_d;
        end
    end

    assign duty_a     = da_q;
    assign duty_b     = db_q;
    assign duty_c     = dc_q;
    assign high_z_a   = hz_q[0];
    assign high_z_b   = hz_q[1];
    assign high_z_c   = hz_q[2];
    assign fault      = fault_q;
    assign hall_count = count_q;
endmodule
